// File: rtl/branch_checkpoint_stack_pkg.sv
// Shared sizes and checkpoint types for the branch checkpoint stack.
package branch_checkpoint_stack_pkg;

    localparam int BRANCH_STACK_DEPTH = 4;
    localparam int PHYS_REG_SZ_R10K   = 64;

    typedef logic [BRANCH_STACK_DEPTH-1:0] branch_mask_t;

    typedef struct packed {
        logic                        valid;
        logic [PHYS_REG_SZ_R10K-1:0] snapshot;
        branch_mask_t                dep_mask;
    } checkpoint_t;

endpackage

// File: rtl/branch_checkpoint_stack_psel.sv
// Lowest-index-first one-hot picker; grants nothing when no request is set.
module branch_checkpoint_stack_psel #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_gnt
);

    logic [WIDTH:0] w_seen;

    assign w_seen[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pick
        assign w_seen[i+1] = w_seen[i] | i_req[i];
        assign o_gnt[i]    = i_req[i] & ~w_seen[i];
    end

endmodule

// File: rtl/branch_checkpoint_stack.sv
// Free-list checkpoints for in-flight branches: allocate at dispatch, release on
// resolve, and on mispredict restore the snapshot and kill all younger dependents.
module branch_checkpoint_stack
    import branch_checkpoint_stack_pkg::*;
#(
    parameter int DEPTH     = BRANCH_STACK_DEPTH,
    parameter int PHYS_REGS = PHYS_REG_SZ_R10K
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_alloc_valid,
    input  logic [PHYS_REGS-1:0]         i_alloc_free_list,
    output logic                         o_alloc_ready,
    output logic [DEPTH-1:0]             o_alloc_tag,
    output logic [DEPTH-1:0]             o_branch_mask,
    input  logic                         i_resolve_valid,
    input  logic [DEPTH-1:0]             i_resolve_tag,
    input  logic                         i_resolve_mispredict,
    output logic                         o_restore_flag,
    output logic [PHYS_REGS-1:0]         o_free_list_restore,
    output logic [DEPTH-1:0]             o_squash_mask,
    output logic [$clog2(DEPTH+1)-1:0]   o_free_slots
);

    localparam int FS_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic                 valid;
        logic [PHYS_REGS-1:0] snapshot;
        logic [DEPTH-1:0]     dep_mask;
    } entry_t;

    entry_t r_ent [DEPTH];
    entry_t w_nxt [DEPTH];

    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0]     w_pick;
    logic                 w_tag_onehot;
    logic                 w_hit;
    logic                 w_restore;
    logic                 w_correct;
    logic                 w_alloc_fire;
    logic [DEPTH-1:0]     w_dependents;
    logic [DEPTH-1:0]     w_squash;
    logic [PHYS_REGS-1:0] w_snap;
    logic [FS_W-1:0]      w_free_cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        assign w_valid[i] = r_ent[i].valid;
    end

    branch_checkpoint_stack_psel #(.WIDTH(DEPTH)) u_psel (
        .i_req (~w_valid),
        .o_gnt (w_pick)
    );

    assign o_alloc_tag   = w_pick;
    assign o_alloc_ready = |(~w_valid);
    assign o_branch_mask = w_valid;

    // Resolves naming a dead slot or more than one slot are dropped entirely.
    assign w_tag_onehot = (i_resolve_tag != '0) &&
                          ((i_resolve_tag & (i_resolve_tag - DEPTH'(1))) == '0);
    assign w_hit        = ~i_reset & i_resolve_valid & w_tag_onehot &
                          (|(i_resolve_tag & w_valid));
    assign w_restore    = w_hit & i_resolve_mispredict;
    assign w_correct    = w_hit & ~i_resolve_mispredict;

    always_comb begin
        w_dependents = '0;
        w_snap       = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_dependents[j] = r_ent[j].valid & (|(r_ent[j].dep_mask & i_resolve_tag));
            w_snap          = w_snap | (r_ent[j].snapshot & {PHYS_REGS{i_resolve_tag[j]}});
        end
    end

    always_comb begin
        w_squash = '0;
        if (w_restore)
            w_squash = i_resolve_tag | w_dependents;
        else if (w_correct)
            w_squash = i_resolve_tag;
    end

    assign o_restore_flag      = w_restore;
    assign o_free_list_restore = w_restore ? w_snap : '0;
    assign o_squash_mask       = w_squash;

    // An allocation alongside a mispredict is on the wrong path, so it never lands.
    assign w_alloc_fire = i_alloc_valid & o_alloc_ready & ~w_restore;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_nxt[j]          = r_ent[j];
            w_nxt[j].dep_mask = r_ent[j].dep_mask & ~w_squash;
            if (w_squash[j])
                w_nxt[j].valid = 1'b0;
            if (w_alloc_fire && w_pick[j]) begin
                w_nxt[j].valid    = 1'b1;
                w_nxt[j].snapshot = i_alloc_free_list;
                w_nxt[j].dep_mask = w_valid & ~w_squash;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int j = 0; j < DEPTH; j++)
                r_ent[j] <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++)
                r_ent[j] <= w_nxt[j];
        end
    end

    always_comb begin
        w_free_cnt = '0;
        for (int j = 0; j < DEPTH; j++)
            if (!w_valid[j])
                w_free_cnt = w_free_cnt + FS_W'(1);
    end

    assign o_free_slots = w_free_cnt;

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Directed scoreboard bench for branch_checkpoint_stack (DEPTH=4, PHYS_REGS=64).
module tb_branch_checkpoint_stack;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_alloc_valid;
    logic [63:0] i_alloc_free_list;
    logic        o_alloc_ready;
    logic [3:0]  o_alloc_tag;
    logic [3:0]  o_branch_mask;
    logic        i_resolve_valid;
    logic [3:0]  i_resolve_tag;
    logic        i_resolve_mispredict;
    logic        o_restore_flag;
    logic [63:0] o_free_list_restore;
    logic [3:0]  o_squash_mask;
    logic [2:0]  o_free_slots;

    always #5 i_clock = ~i_clock;

    branch_checkpoint_stack #(.DEPTH(4), .PHYS_REGS(64)) dut (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_alloc_valid        (i_alloc_valid),
        .i_alloc_free_list    (i_alloc_free_list),
        .o_alloc_ready        (o_alloc_ready),
        .o_alloc_tag          (o_alloc_tag),
        .o_branch_mask        (o_branch_mask),
        .i_resolve_valid      (i_resolve_valid),
        .i_resolve_tag        (i_resolve_tag),
        .i_resolve_mispredict (i_resolve_mispredict),
        .o_restore_flag       (o_restore_flag),
        .o_free_list_restore  (o_free_list_restore),
        .o_squash_mask        (o_squash_mask),
        .o_free_slots         (o_free_slots)
    );

    typedef struct {
        logic        rdy;
        logic [3:0]  tag;
        logic [3:0]  bm;
        logic        rf;
        logic [63:0] flr;
        logic [3:0]  sq;
        logic [2:0]  fs;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    total = 0;
    int    bad   = 0;

    localparam logic [63:0] SA  = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] SB  = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] SC  = 64'hCCCC_0000_0000_0004;
    localparam logic [63:0] SD  = 64'hDDDD_0000_0000_0008;
    localparam logic [63:0] SE  = 64'hEEEE_0000_0000_0010;
    localparam logic [63:0] SB2 = 64'hB2B2_1111_2222_3333;
    localparam logic [63:0] SC2 = 64'hC2C2_4444_5555_6666;
    localparam logic [63:0] SD2 = 64'hD2D2_7777_8888_9999;
    localparam logic [63:0] SA2 = 64'hA2A2_ABCD_EF01_2345;
    localparam logic [63:0] SA3 = 64'hA3A3_0F0F_0F0F_0F0F;
    localparam logic [63:0] SX  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] SY  = 64'h0FED_CBA9_8765_4321;
    localparam logic [63:0] SZ  = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] SP  = 64'h0000_FFFF_0000_FFFF;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the oldest queued expectation.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge i_clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, "alloc_ready",  64'(o_alloc_ready),       64'(e.rdy));
                chk(n, "alloc_tag",    64'(o_alloc_tag),         64'(e.tag));
                chk(n, "branch_mask",  64'(o_branch_mask),       64'(e.bm));
                chk(n, "restore_flag", 64'(o_restore_flag),      64'(e.rf));
                chk(n, "restore_val",  o_free_list_restore,      e.flr);
                chk(n, "squash_mask",  64'(o_squash_mask),       64'(e.sq));
                chk(n, "free_slots",   64'(o_free_slots),        64'(e.fs));
            end
        end
    end

    task automatic step(
        input logic rst, input logic av, input logic [63:0] afl,
        input logic rv, input logic [3:0] rt, input logic rm,
        input logic x_rdy, input logic [3:0] x_tag, input logic [3:0] x_bm,
        input logic x_rf, input logic [63:0] x_flr, input logic [3:0] x_sq,
        input logic [2:0] x_fs, input string nm);
        exp_t e;
        i_reset              = rst;
        i_alloc_valid        = av;
        i_alloc_free_list    = afl;
        i_resolve_valid      = rv;
        i_resolve_tag        = rt;
        i_resolve_mispredict = rm;
        e.rdy = x_rdy; e.tag = x_tag; e.bm = x_bm; e.rf = x_rf;
        e.flr = x_flr; e.sq = x_sq; e.fs = x_fs;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        i_reset = 1'b1; i_alloc_valid = 1'b0; i_alloc_free_list = '0;
        i_resolve_valid = 1'b0; i_resolve_tag = '0; i_resolve_mispredict = 1'b0;
        @(posedge i_clock);
        #1;
        //   rst av afl  rv rt     rm   rdy tag      bm       rf flr  sq       fs
        step(1, 0, '0,  0, 4'h0, 0,   1, 4'b0001, 4'b0000, 0, '0,  4'b0000, 3'd4, "reset");
        step(0, 1, SA,  0, 4'h0, 0,   1, 4'b0001, 4'b0000, 0, '0,  4'b0000, 3'd4, "alloc_a");
        step(0, 1, SB,  0, 4'h0, 0,   1, 4'b0010, 4'b0001, 0, '0,  4'b0000, 3'd3, "alloc_b");
        step(0, 1, SC,  0, 4'h0, 0,   1, 4'b0100, 4'b0011, 0, '0,  4'b0000, 3'd2, "alloc_c");
        step(0, 1, SD,  0, 4'h0, 0,   1, 4'b1000, 4'b0111, 0, '0,  4'b0000, 3'd1, "alloc_d");
        step(0, 1, SE,  0, 4'h0, 0,   0, 4'b0000, 4'b1111, 0, '0,  4'b0000, 3'd0, "alloc_full");
        step(0, 0, '0,  0, 4'h0, 0,   0, 4'b0000, 4'b1111, 0, '0,  4'b0000, 3'd0, "full_hold");
        step(0, 0, '0,  1, 4'b0010, 1, 0, 4'b0000, 4'b1111, 1, SB, 4'b1110, 3'd0, "mispred_b");
        step(0, 1, SB2, 0, 4'h0, 0,   1, 4'b0010, 4'b0001, 0, '0,  4'b0000, 3'd3, "after_mp_b");
        step(0, 1, SC2, 0, 4'h0, 0,   1, 4'b0100, 4'b0011, 0, '0,  4'b0000, 3'd2, "refill_c");
        step(0, 1, SD2, 0, 4'h0, 0,   1, 4'b1000, 4'b0111, 0, '0,  4'b0000, 3'd1, "refill_d");
        step(0, 1, SE,  1, 4'b0001, 0, 0, 4'b0000, 4'b1111, 0, '0, 4'b0001, 3'd0, "full_correct");
        step(0, 1, SA2, 0, 4'h0, 0,   1, 4'b0001, 4'b1110, 0, '0,  4'b0000, 3'd1, "after_correct");
        step(0, 0, '0,  1, 4'b0001, 1, 0, 4'b0000, 4'b1111, 1, SA2, 4'b0001, 3'd0, "dep_bit0_clear");
        step(0, 1, SA3, 1, 4'b0100, 0, 1, 4'b0001, 4'b1110, 0, '0, 4'b0100, 3'd1, "correct_alloc");
        step(0, 0, '0,  1, 4'b0010, 1, 1, 4'b0100, 4'b1011, 1, SB2, 4'b1011, 3'd1, "mispred_deps");
        step(0, 0, '0,  1, 4'b0100, 1, 1, 4'b0001, 4'b0000, 0, '0, 4'b0000, 3'd4, "invalid_tag");
        step(0, 1, SX,  0, 4'h0, 0,   1, 4'b0001, 4'b0000, 0, '0,  4'b0000, 3'd4, "alloc_x");
        step(0, 1, SY,  0, 4'h0, 0,   1, 4'b0010, 4'b0001, 0, '0,  4'b0000, 3'd3, "alloc_y");
        step(0, 1, SZ,  1, 4'b0001, 1, 1, 4'b0100, 4'b0011, 1, SX, 4'b0011, 3'd2, "mp_with_alloc");
        step(0, 1, SP,  0, 4'h0, 0,   1, 4'b0001, 4'b0000, 0, '0,  4'b0000, 3'd4, "alloc_discarded");
        step(0, 0, '0,  1, 4'b0011, 1, 1, 4'b0010, 4'b0001, 0, '0, 4'b0000, 3'd3, "multi_hot_tag");
        step(1, 1, SZ,  1, 4'b0001, 1, 1, 4'b0010, 4'b0001, 0, '0, 4'b0000, 3'd3, "reset_mid");
        step(0, 0, '0,  0, 4'h0, 0,   1, 4'b0001, 4'b0000, 0, '0,  4'b0000, 3'd4, "after_reset");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge i_clock);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
